// File: rtl/template_match_scorer_pkg.sv
// Shared constants and FSM encoding for the template ROM, the scorer and the decision logic.
package template_match_scorer_pkg;
  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 8;
  localparam int PIX_TOL    = 8;
  localparam int HIT_MIN    = 1536;
  localparam int TMPL_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/template_match_scorer_if.sv
// Sample stream, template ROM port and result bus of the scorer.
interface template_match_scorer_if
  import template_match_scorer_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
);
  logic          start;
  logic          busy;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_last;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data;
  logic          done;
  logic [AW+DW-1:0] sad;
  logic [AW:0]   match_cnt;
  logic          hit;
  logic          err_len;

  modport master (
    output start, pix_valid, pix_data, pix_last, rom_rd_data,
    input  busy, pix_ready, rom_addr, done, sad, match_cnt, hit, err_len
  );
  modport slave (
    input  start, pix_valid, pix_data, pix_last, rom_rd_data,
    output busy, pix_ready, rom_addr, done, sad, match_cnt, hit, err_len
  );
endinterface

// File: rtl/template_match_scorer_abs_diff_stage.sv
// Registered |a-b| with its valid bit; the valid travels with the data so bubbles pass through.
module abs_diff_stage #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_vld,
  output logic [DW-1:0] o_diff
);
  logic          r_vld;
  logic [DW-1:0] r_diff;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_diff <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) r_diff <= (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    end
  end

  assign o_vld  = r_vld;
  assign o_diff = r_diff;
endmodule

// File: rtl/template_match_scorer.sv
// Streams one feature vector against the template ROM, accumulating SAD and a per-sample match count.
module template_match_scorer
  import template_match_scorer_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  template_match_scorer_if.slave bus
);
  localparam logic [DW-1:0] TOL  = DW'(PIX_TOL);
  localparam logic [AW:0]   HMIN = (AW+1)'(HIT_MIN);

  state_t           r_state, w_next;
  logic [AW-1:0]    r_idx;
  logic [DW-1:0]    r_pix_q;
  logic             r_pix_vld;
  logic [AW+DW-1:0] r_sad;
  logic [AW:0]      r_cnt;
  logic             r_hit, r_err;
  logic             w_diff_vld;
  logic [DW-1:0]    w_diff;
  logic             w_accept, w_final, w_drained, w_match;

  assign w_accept  = (r_state == S_RUN) && bus.pix_valid;
  assign w_final   = w_accept && (bus.pix_last || (r_idx == '1));
  assign w_drained = !r_pix_vld && !w_diff_vld;
  assign w_match   = (w_diff <= TOL);

  // ROM data for the sample in r_pix_q arrives on the same cycle, so both feed stage 1 together.
  abs_diff_stage #(.DW(DW)) u_diff (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_vld  (r_pix_vld),
    .i_a    (r_pix_q),
    .i_b    (bus.rom_rd_data),
    .o_vld  (w_diff_vld),
    .o_diff (w_diff)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_final)   w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pix_q   <= '0;
      r_pix_vld <= 1'b0;
      r_sad     <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pix_vld <= w_accept;
      if (w_accept) r_pix_q <= bus.pix_data;
      if (r_state == S_IDLE && bus.start) begin
        r_idx <= '0;
        r_sad <= '0;
        r_cnt <= '0;
        r_hit <= 1'b0;
        r_err <= 1'b0;
      end
      // Length is good only when pix_last lands exactly on the final template index.
      if (w_accept) begin
        r_idx <= w_final ? '0 : r_idx + AW'(1);
        if (w_final) r_err <= !(bus.pix_last && (r_idx == '1));
      end
      if (w_diff_vld) begin
        r_sad <= r_sad + {{AW{1'b0}}, w_diff};
        r_cnt <= r_cnt + {{AW{1'b0}}, w_match};
      end
      if (r_state == S_DRAIN && w_drained) r_hit <= (r_cnt >= HMIN) && !r_err;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.pix_ready = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.rom_addr  = r_idx;
  assign bus.sad       = r_sad;
  assign bus.match_cnt = r_cnt;
  assign bus.hit       = r_hit;
  assign bus.err_len   = r_err;
endmodule

// File: tb/tb_template_match_scorer.sv
// Directed bench for template_match_scorer: per-cycle model comparison plus literal result checks.
module tb_template_match_scorer;
  import template_match_scorer_pkg::*;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  template_match_scorer_if bus();
  template_match_scorer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  logic [DW-1:0] rom [N];
  always @(posedge clk) bus.rom_rd_data <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Model: remembers every accepted sample; results are recomputed from the ROM contents at done time.
  bit   chk_en = 0;
  bit   m_busy = 0, m_run = 0, m_hit = 0, m_err = 0;
  int   n_acc = 0, exp_done = -1, n_done = 0;
  int   pix_q[$];
  int   m_sad = 0, m_cnt = 0;

  always @(negedge clk) begin : model
    bit busy_now;
    int s, c, d;
    if (chk_en) begin
      busy_now = m_busy;
      if (cyc == exp_done) begin
        s = 0; c = 0;
        foreach (pix_q[k]) begin
          d = pix_q[k] - int'(rom[k]);
          if (d < 0) d = -d;
          s += d;
          if (d <= PIX_TOL) c++;
        end
        m_sad = s; m_cnt = c;
        m_hit = (c >= HIT_MIN) && !m_err;
      end
      chk("done", bus.done, cyc == exp_done);
      chk("busy", bus.busy, m_busy);
      chk("pix_ready", bus.pix_ready, m_run);
      chk("rom_addr", bus.rom_addr, m_run ? n_acc : 0);
      if (!m_busy || cyc == exp_done) begin
        chk("sad", bus.sad, m_sad);
        chk("match_cnt", bus.match_cnt, m_cnt);
        chk("hit", bus.hit, m_hit);
        chk("err_len", bus.err_len, m_err);
      end
      if (bus.done === 1'b1) n_done++;
      if (cyc == exp_done) begin m_busy = 0; exp_done = -1; end
      if (!rst_n) begin
        m_busy = 0; m_run = 0; exp_done = -1; n_acc = 0; pix_q.delete();
        m_sad = 0; m_cnt = 0; m_hit = 0; m_err = 0;
      end else if (!busy_now && bus.start) begin
        m_busy = 1; m_run = 1; n_acc = 0; pix_q.delete();
        m_sad = 0; m_cnt = 0; m_hit = 0; m_err = 0;
      end else if (m_run && bus.pix_valid) begin
        pix_q.push_back(int'(bus.pix_data));
        n_acc++;
        if (bus.pix_last || n_acc == N) begin
          m_run = 0;
          exp_done = cyc + 4;
          m_err = !(bus.pix_last && n_acc == N);
        end
      end
    end
  end

  function automatic logic [DW-1:0] pix_val(int mode, int i);
    logic [7:0] a;
    a = i[7:0];
    case (mode)
      0:       return 8'hFF;
      1:       return 8'h00;
      default: return (a < 8'd252) ? a + 8'd4 : a - 8'd4;
    endcase
  endfunction

  task automatic fill_rom(input bit ramp);
    for (int a = 0; a < N; a++) begin
      logic [AW-1:0] av;
      av = AW'(a);
      rom[a] = ramp ? av[7:0] : 8'hFF;
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic stream(input int mode, input int gap, input int last_at,
                        input int rst_at, input int start_at);
    for (int i = 0; i < N; i++) begin
      if (i == rst_at) begin
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      for (int g = 0; g < 6 && gap > 0 && $urandom_range(0, 99) < gap; g++) begin
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_val(mode, i);
      bus.pix_last  = (i == last_at);
      bus.start     = (i == start_at);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (i == last_at) break;
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int e_sad, input int e_cnt,
                            input bit e_hit, input bit e_err, input int d0);
    int t;
    t = 0;
    while (bus.done !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_latency"}, t, 3);
    chk({nm, "_sad"}, bus.sad, e_sad);
    chk({nm, "_cnt"}, bus.match_cnt, e_cnt);
    chk({nm, "_hit"}, bus.hit, e_hit);
    chk({nm, "_err"}, bus.err_len, e_err);
    @(posedge clk); #1;
    chk({nm, "_pulses"}, n_done - d0, 1);
    chk({nm, "_idle"}, bus.busy, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    bus.start = 0; bus.pix_valid = 0; bus.pix_data = 0; bus.pix_last = 0;
    fill_rom(1'b0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;
    chk("rst_sad", bus.sad, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.pix_ready, 0);

    d0 = n_done; do_start(); stream(0, 0, N-1, -1, -1);
    finish_run("s1", 0, 2048, 1, 0, d0);

    d0 = n_done; do_start(); stream(1, 0, N-1, -1, -1);
    finish_run("s2", 522240, 0, 0, 0, d0);

    fill_rom(1'b1);
    d0 = n_done; do_start(); stream(2, 30, N-1, -1, -1);
    finish_run("s3", 8192, 2048, 1, 0, d0);

    fill_rom(1'b0);
    d0 = n_done; do_start(); stream(0, 0, 100, -1, -1);
    finish_run("s4", 0, 101, 0, 1, d0);
    d0 = n_done; do_start(); stream(0, 0, N-1, -1, -1);
    finish_run("s4b", 0, 2048, 1, 0, d0);

    d0 = n_done; do_start(); stream(0, 0, N-1, 1000, -1);
    repeat (5) @(posedge clk); #1;
    chk("s5_sad", bus.sad, 0);
    chk("s5_cnt", bus.match_cnt, 0);
    chk("s5_hit", bus.hit, 0);
    chk("s5_err", bus.err_len, 0);
    chk("s5_busy", bus.busy, 0);
    chk("s5_addr", bus.rom_addr, 0);
    chk("s5_nodone", n_done - d0, 0);
    d0 = n_done; do_start(); stream(0, 0, N-1, -1, -1);
    finish_run("s5b", 0, 2048, 1, 0, d0);

    fill_rom(1'b1);
    d0 = n_done; do_start(); stream(2, 10, N-1, -1, 500);
    finish_run("s6", 8192, 2048, 1, 0, d0);

    repeat (3) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
